// File: rtl/cordic_result_serializer.sv
// Output stage behind the CORDIC core: queues {phase, magnitude} results in a small
// FIFO and streams each one as six bytes, LSB first, over a valid/ready byte port.
module cordic_result_serializer #(
  parameter int DEPTH = 2,
  parameter int MAG_W = 16,
  parameter int PH_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic [MAG_W-1:0]           res_mag,
  input  logic [PH_W-1:0]            res_phase,
  input  logic                       flush,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = MAG_W + PH_W;
  localparam int NBYTES = EW / 8;

  generate
    if (MAG_W != 16 || PH_W != 32) begin : g_bad_width
      $error("cordic_result_serializer: MAG_W must be 16 and PH_W must be 32");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("cordic_result_serializer: DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [2:0]      byte_idx_q, byte_idx_d;

  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   head;
  logic [7:0]      head_bytes [NBYTES];

  logic            push, xfer, pop, empty, last_byte;

  assign empty     = (level_q == '0);
  assign res_ready = (level_q != LW'(DEPTH));
  assign out_valid = !empty;
  assign level     = level_q;
  assign busy      = (state_q == SEND);

  assign push      = res_valid && res_ready;
  assign xfer      = out_valid && out_ready;
  assign last_byte = (byte_idx_q == 3'(NBYTES - 1));
  assign pop       = xfer && last_byte;

  // Storage is data only; validity is tracked entirely by level/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {res_phase, res_mag};
    end
  end

  assign head = mem_q[rd_ptr_q];

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_bytes
      assign head_bytes[gi] = head[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    out_data = 8'h00;
    if (!empty) begin
      case (byte_idx_q)
        3'd0:    out_data = head_bytes[0];
        3'd1:    out_data = head_bytes[1];
        3'd2:    out_data = head_bytes[2];
        3'd3:    out_data = head_bytes[3];
        3'd4:    out_data = head_bytes[4];
        3'd5:    out_data = head_bytes[5];
        default: out_data = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    byte_idx_d = byte_idx_q;
    if (flush) begin
      // Flush wins over any same-cycle push or byte transfer.
      state_d    = IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      byte_idx_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (xfer) begin
        if (last_byte) begin
          byte_idx_d = '0;
          rd_ptr_d   = rd_ptr_q + 1'b1;
        end else begin
          byte_idx_d = byte_idx_q + 3'd1;
        end
      end
      level_d = level_q + LW'(push) - LW'(pop);
      case (state_q)
        IDLE:    if (push) state_d = SEND;
        SEND:    if (pop && level_q == LW'(1) && !push) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      byte_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      byte_idx_q <= byte_idx_d;
    end
  end

endmodule
